// File: rtl/count_pwm_gen_if.sv
// Control and status bundle between the count source and the PWM generator.
interface count_pwm_gen_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic [WIDTH-1:0] duty;
  logic [WIDTH-1:0] period;
  logic             pwm;
  logic             period_start;
  logic             busy;
  logic [WIDTH-1:0] duty_q;

  modport master (
    output en, duty, period,
    input  pwm, period_start, busy, duty_q
  );

  modport slave (
    input  en, duty, period,
    output pwm, period_start, busy, duty_q
  );
endinterface

// File: rtl/count_pwm_gen.sv
// PWM generator driven by a live count; duty/period are latched only at period
// boundaries so the waveform never carries runt pulses.
module count_pwm_gen #(
  parameter int unsigned WIDTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  count_pwm_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] phase;
  logic [WIDTH-1:0] phase_nxt;
  logic [WIDTH-1:0] duty_r;
  logic [WIDTH-1:0] duty_nxt;
  logic [WIDTH-1:0] period_q;
  logic [WIDTH-1:0] period_nxt;
  logic             active;
  logic             terminal;

  // State and period-scoped operand registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      phase    <= '0;
      duty_r   <= '0;
      period_q <= '0;
    end else begin
      state    <= state_nxt;
      phase    <= phase_nxt;
      duty_r   <= duty_nxt;
      period_q <= period_nxt;
    end
  end

  assign terminal = (phase == period_q);

  // Next-state: STOP keeps the waveform running until the terminal phase
  always_comb begin
    state_nxt  = state;
    phase_nxt  = phase;
    duty_nxt   = duty_r;
    period_nxt = period_q;
    case (state)
      IDLE: begin
        if (bus.en) begin
          state_nxt  = RUN;
          phase_nxt  = '0;
          duty_nxt   = bus.duty;
          period_nxt = bus.period;
        end
      end
      RUN, STOP: begin
        if (terminal) begin
          phase_nxt = '0;
          if (bus.en) begin
            state_nxt  = RUN;
            duty_nxt   = bus.duty;
            period_nxt = bus.period;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          phase_nxt = WIDTH'(phase + 1'b1);
          state_nxt = bus.en ? RUN : STOP;
        end
      end
      default: begin
        state_nxt = IDLE;
        phase_nxt = '0;
      end
    endcase
  end

  // Outputs decode registered state only; no input reaches them combinationally
  assign active           = (state != IDLE);
  assign bus.busy         = active;
  assign bus.pwm          = active & (phase < duty_r);
  assign bus.period_start = active & (phase == '0);
  assign bus.duty_q       = duty_r;

endmodule

// File: tb/tb_count_pwm_gen.sv
// Directed bench for count_pwm_gen: a vector table for steady-state waveforms plus
// hand-written sequences for reload, early disable and mid-period reset.
module tb_count_pwm_gen;

  logic clk;
  logic reset;

  count_pwm_gen_if #(.WIDTH(8)) bus ();

  count_pwm_gen #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] duty;
    logic [7:0] period;
    logic       pwm;
    logic       ps;
    logic       busy;
    logic [7:0] dq;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic r, input logic e, input logic [7:0] d, input logic [7:0] p,
                     input logic x_pwm, input logic x_ps, input logic x_busy, input logic [7:0] x_dq);
    vec_t v;
    v.rst = r; v.en = e; v.duty = d; v.period = p;
    v.pwm = x_pwm; v.ps = x_ps; v.busy = x_busy; v.dq = x_dq;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0d want=%0d", nm, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the capturing edge
  task automatic step(input logic r, input logic e, input logic [7:0] d, input logic [7:0] p);
    reset      = r;
    bus.en     = e;
    bus.duty   = d;
    bus.period = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; bus.en = 1'b0; bus.duty = 8'd0; bus.period = 8'd0;

    // Reset held with en=1, then steady duty 3 / period 9
    for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 8'd3, 8'd9, 1'b0, 1'b0, 1'b0, 8'd0);
    for (int k = 0; k < 20; k++) add(1'b0, 1'b1, 8'd3, 8'd9, (k % 10) < 3, (k % 10) == 0, 1'b1, 8'd3);
    // duty=0 never high
    add(1'b1, 1'b0, 8'd0, 8'd9, 1'b0, 1'b0, 1'b0, 8'd0);
    for (int k = 0; k < 12; k++) add(1'b0, 1'b1, 8'd0, 8'd9, 1'b0, (k % 10) == 0, 1'b1, 8'd0);
    // duty far above period -> always high
    add(1'b1, 1'b0, 8'd0, 8'd9, 1'b0, 1'b0, 1'b0, 8'd0);
    for (int k = 0; k < 12; k++) add(1'b0, 1'b1, 8'd200, 8'd9, 1'b1, (k % 10) == 0, 1'b1, 8'd200);
    // duty == period -> exactly one low cycle
    add(1'b1, 1'b0, 8'd0, 8'd9, 1'b0, 1'b0, 1'b0, 8'd0);
    for (int k = 0; k < 12; k++) add(1'b0, 1'b1, 8'd9, 8'd9, (k % 10) < 9, (k % 10) == 0, 1'b1, 8'd9);
    // duty == period+1 -> always high
    add(1'b1, 1'b0, 8'd0, 8'd9, 1'b0, 1'b0, 1'b0, 8'd0);
    for (int k = 0; k < 12; k++) add(1'b0, 1'b1, 8'd10, 8'd9, 1'b1, (k % 10) == 0, 1'b1, 8'd10);
    // period=0 -> 1-cycle periods
    add(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    for (int k = 0; k < 5; k++) add(1'b0, 1'b1, 8'd1, 8'd0, 1'b1, 1'b1, 1'b1, 8'd1);

    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].en, vq[i].duty, vq[i].period);
      chk("tbl_pwm",  i, 32'(bus.pwm),          32'(vq[i].pwm));
      chk("tbl_ps",   i, 32'(bus.period_start), 32'(vq[i].ps));
      chk("tbl_busy", i, 32'(bus.busy),         32'(vq[i].busy));
      chk("tbl_dq",   i, 32'(bus.duty_q),       32'(vq[i].dq));
    end

    // Ramping duty (with upstream wrap): duty_q only changes at reload edges
    step(1'b1, 1'b0, 8'd0, 8'd9);
    for (int k = 0; k < 30; k++) begin
      int ph;
      int xdq;
      int xpwm;
      ph   = k % 10;
      xdq  = (k < 10) ? 250 : ((k < 20) ? 4 : 14);
      xpwm = (k < 10) ? 1 : ((k < 20) ? int'(ph < 4) : 1);
      step(1'b0, 1'b1, 8'(250 + k), 8'd9);
      chk("ramp_dq",  k, 32'(bus.duty_q),       32'(xdq));
      chk("ramp_pwm", k, 32'(bus.pwm),          32'(xpwm));
      chk("ramp_ps",  k, 32'(bus.period_start), 32'(ph == 0));
    end

    // Drop en mid-period: period completes, then IDLE
    step(1'b1, 1'b0, 8'd0, 8'd9);
    for (int k = 0; k < 12; k++) begin
      step(1'b0, k < 3, 8'd5, 8'd9);
      chk("stop_busy", k, 32'(bus.busy),         32'(k < 10));
      chk("stop_pwm",  k, 32'(bus.pwm),          32'(k < 5));
      chk("stop_ps",   k, 32'(bus.period_start), 32'(k == 0));
    end

    // Drop then re-raise en within the period: no gap into the next period
    step(1'b1, 1'b0, 8'd0, 8'd9);
    for (int k = 0; k < 15; k++) begin
      step(1'b0, (k < 3) || (k >= 7), 8'd5, 8'd9);
      chk("rerun_busy", k, 32'(bus.busy),         32'd1);
      chk("rerun_pwm",  k, 32'(bus.pwm),          32'((k % 10) < 5));
      chk("rerun_ps",   k, 32'(bus.period_start), 32'((k % 10) == 0));
    end

    // Reset mid-period, then restart with en still high
    step(1'b1, 1'b0, 8'd0, 8'd9);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 8'd5, 8'd9);
    step(1'b1, 1'b1, 8'd5, 8'd9);
    chk("mrst_busy", 0, 32'(bus.busy),         32'd0);
    chk("mrst_pwm",  0, 32'(bus.pwm),          32'd0);
    chk("mrst_ps",   0, 32'(bus.period_start), 32'd0);
    chk("mrst_dq",   0, 32'(bus.duty_q),       32'd0);
    step(1'b0, 1'b1, 8'd5, 8'd9);
    chk("mrst_busy", 1, 32'(bus.busy),         32'd1);
    chk("mrst_ps",   1, 32'(bus.period_start), 32'd1);
    chk("mrst_pwm",  1, 32'(bus.pwm),          32'd1);
    chk("mrst_dq",   1, 32'(bus.duty_q),       32'd5);
    step(1'b0, 1'b1, 8'd5, 8'd9);
    chk("mrst_ps",   2, 32'(bus.period_start), 32'd0);
    chk("mrst_pwm",  2, 32'(bus.pwm),          32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
